// File: rtl/matrix_calculator_dispval_bank.sv
// Banked output register: per-channel staged values committed atomically to live outputs.
// Reads are 1-cycle registered; commits come from a CTRL write, auto mode, or a periodic timer.
module matrix_calculator_dispval_bank #(
    parameter int          NUM_CH        = 4,
    parameter int          DATA_W        = 32,
    parameter logic [31:0] RESET_VAL     = 32'h0,
    parameter int          COMMIT_PERIOD = 0,
    localparam int         CH_BITS       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         AW            = CH_BITS + 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AW-1:0]            address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     update
);

    localparam int                CNT_W   = (COMMIT_PERIOD > 1) ? $clog2(COMMIT_PERIOD) : 1;
    localparam logic [DATA_W-1:0] RST_V   = RESET_VAL[DATA_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_MAX = (COMMIT_PERIOD > 0) ? CNT_W'(COMMIT_PERIOD - 1) : '0;

    logic [DATA_W-1:0]  stage_q [NUM_CH];
    logic [DATA_W-1:0]  stage_d [NUM_CH];
    logic [DATA_W-1:0]  live_q  [NUM_CH];
    logic               auto_q, auto_d;
    logic               pending_q, pending_d;
    logic               auto_commit_q;
    logic               update_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        readdata_q, readdata_d;

    logic               is_ctl, wr_en, rd_en, ch_ok;
    logic               stage_wr, ctrl_wr, periodic, commit;
    logic [CH_BITS-1:0] ch;
    logic [1:0]         rsel;
    logic [DATA_W-1:0]  wd;
    logic               unused_bits;

    assign is_ctl      = address[AW-1];
    assign ch          = address[AW-2:2];
    assign rsel        = address[1:0];
    assign wd          = writedata[DATA_W-1:0];
    assign wr_en       = chipselect & ~write_n;
    assign rd_en       = chipselect & write_n;
    assign ch_ok       = (int'(ch) < NUM_CH);
    assign unused_bits = ^{writedata, address};

    assign stage_wr = wr_en & ~is_ctl & ch_ok & (rsel != 2'd1);
    assign ctrl_wr  = wr_en & is_ctl & (rsel == 2'd0);
    assign periodic = (COMMIT_PERIOD > 0) && (cnt_q == CNT_MAX) && pending_q;
    // All commit sources merge into one strobe so coincident requests yield a single pulse.
    assign commit   = (ctrl_wr & writedata[1]) | auto_commit_q | periodic;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            stage_d[i] = stage_q[i];
            if (stage_wr && int'(ch) == i) begin
                case (rsel)
                    2'd0:    stage_d[i] = wd;
                    2'd2:    stage_d[i] = stage_q[i] | wd;
                    default: stage_d[i] = stage_q[i] & ~wd;
                endcase
            end
        end
    end

    always_comb begin
        auto_d    = ctrl_wr ? writedata[0] : auto_q;
        pending_d = stage_wr ? 1'b1 : (commit ? 1'b0 : pending_q);
        cnt_d     = '0;
        if (COMMIT_PERIOD > 1) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        readdata_d = '0;
        if (rd_en) begin
            if (is_ctl) begin
                case (rsel)
                    2'd0:    readdata_d[0] = auto_q;
                    2'd1:    readdata_d[0] = pending_q;
                    default: readdata_d    = '0;
                endcase
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (int'(ch) == i) begin
                        case (rsel)
                            2'd0:    readdata_d[DATA_W-1:0] = stage_q[i];
                            2'd1:    readdata_d[DATA_W-1:0] = live_q[i];
                            default: readdata_d             = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= RST_V;
                live_q[i]  <= RST_V;
            end
            auto_q        <= 1'b0;
            pending_q     <= 1'b0;
            auto_commit_q <= 1'b0;
            update_q      <= 1'b0;
            cnt_q         <= '0;
            readdata_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= stage_d[i];
                if (commit) begin
                    live_q[i] <= stage_q[i];
                end
            end
            auto_q        <= auto_d;
            pending_q     <= pending_d;
            auto_commit_q <= stage_wr & auto_q;
            update_q      <= commit;
            cnt_q         <= cnt_d;
            readdata_q    <= readdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_port[g*DATA_W +: DATA_W] = live_q[g];
    end

    assign readdata = readdata_q;
    assign update   = update_q;

endmodule
